// File: rtl/aesl_deadlock_pkg.sv
// Shared types and helpers for the AXI-Stream deadlock monitor source end.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a; channel stall semantics are decoded in axis_stall_counter.
package aesl_deadlock_pkg;

  // Ceiling log2 for parameter arithmetic; clog2(1) == 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Index width for a channel number, never narrower than one bit.
  function automatic int ch_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Direction of a channel as seen from the monitored instance.
  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } ch_dir_e;

  // Sticky-record clear handshake states.
  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_ACK  = 1'b1
  } clr_state_e;

endpackage

// File: rtl/axis_stall_counter.sv
// One channel's stall decode, saturating consecutive-stall counter and block bit.
// Latency: block bit registered; rises on the edge ending the THRESH-th stalled cycle.
// Backpressure: observes tvalid/tready only, never drives or stalls the channel.
module axis_stall_counter
  import aesl_deadlock_pkg::*;
#(
  parameter int THRESH = 1024,
  parameter int CNT_W  = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic tvalid,
  input  logic tready,
  input  logic dir,
  input  logic en,
  input  logic idle,
  output logic blk,
  output logic blk_next
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(THRESH);

  logic             stall;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blk_q, blk_d;

  // Stall decode and saturating count; any non-stall cycle restarts the run.
  always_comb begin
    stall = en & ~idle & ((ch_dir_e'(dir) == DIR_WRITE) ? (tvalid & ~tready)
                                                        : (tready & ~tvalid));
    cnt_d = '0;
    if (stall) begin
      cnt_d = (cnt_q == SAT) ? cnt_q : cnt_q + 1'b1;
    end
    blk_d = (cnt_d == SAT);
  end

  // Counter and block bit state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      blk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      blk_q <= blk_d;
    end
  end

  assign blk      = blk_q;
  assign blk_next = blk_d;

endmodule

// File: rtl/axis_block_detector.sv
// Per-channel AXI-Stream block detection plus sticky first-block record with timestamp.
// Latency: block bits and any_block registered together; record captured on the rising edge.
// Backpressure: passive monitor; clr_req is acked one cycle later, at most every second cycle.
module axis_block_detector
  import aesl_deadlock_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int THRESH = 1024,
  parameter int CNT_W  = 16,
  parameter int TS_W   = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         ch_tvalid,
  input  logic [NUM_CH-1:0]         ch_tready,
  input  logic [NUM_CH-1:0]         ch_dir,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic                      inst_idle,
  output logic [NUM_CH-1:0]         axis_block_sigs,
  output logic                      any_block,
  output logic                      first_valid,
  output logic [ch_w(NUM_CH)-1:0]   first_ch,
  output logic [TS_W-1:0]           first_ts,
  input  logic                      clr_req,
  output logic                      clr_ack
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] blk_q, blk_d, rise;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              any_block_q;
  logic              first_valid_q, first_valid_d;
  logic [CH_W-1:0]   first_ch_q, first_ch_d;
  logic [TS_W-1:0]   first_ts_q, first_ts_d;
  clr_state_e        clr_state_q;
  logic              clr_ack_q;
  logic              clr_fire;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    axis_stall_counter #(
      .THRESH (THRESH),
      .CNT_W  (CNT_W)
    ) u_cnt (
      .clock    (clock),
      .reset    (reset),
      .tvalid   (ch_tvalid[i]),
      .tready   (ch_tready[i]),
      .dir      (ch_dir[i]),
      .en       (ch_en[i]),
      .idle     (inst_idle),
      .blk      (blk_q[i]),
      .blk_next (blk_d[i])
    );
  end

  // Timestamp advance and first-block record; a clear beats a same-cycle rise.
  always_comb begin
    ts_d          = ts_q + 1'b1;
    rise          = blk_d & ~blk_q;
    clr_fire      = (clr_state_q == CLR_IDLE) & clr_req;
    first_valid_d = first_valid_q;
    first_ch_d    = first_ch_q;
    first_ts_d    = first_ts_q;
    if (clr_fire) begin
      first_valid_d = 1'b0;
      first_ch_d    = '0;
      first_ts_d    = '0;
    end else if (!first_valid_q && (|rise)) begin
      first_valid_d = 1'b1;
      first_ts_d    = ts_q;
      // Walk downward so the lowest rising index is the one kept.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (rise[i]) first_ch_d = CH_W'(i);
      end
    end
  end

  // Timestamp, any_block and record registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts_q          <= '0;
      any_block_q   <= 1'b0;
      first_valid_q <= 1'b0;
      first_ch_q    <= '0;
      first_ts_q    <= '0;
    end else begin
      ts_q          <= ts_d;
      any_block_q   <= |blk_d;
      first_valid_q <= first_valid_d;
      first_ch_q    <= first_ch_d;
      first_ts_q    <= first_ts_d;
    end
  end

  // Clear handshake FSM: ack one cycle after a request seen in IDLE, then back to IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clr_state_q <= CLR_IDLE;
      clr_ack_q   <= 1'b0;
    end else begin
      case (clr_state_q)
        CLR_IDLE: begin
          if (clr_req) begin
            clr_state_q <= CLR_ACK;
            clr_ack_q   <= 1'b1;
          end else begin
            clr_ack_q   <= 1'b0;
          end
        end
        CLR_ACK: begin
          clr_state_q <= CLR_IDLE;
          clr_ack_q   <= 1'b0;
        end
        default: begin
          clr_state_q <= CLR_IDLE;
          clr_ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign axis_block_sigs = blk_q;
  assign any_block       = any_block_q;
  assign first_valid     = first_valid_q;
  assign first_ch        = first_ch_q;
  assign first_ts        = first_ts_q;
  assign clr_ack         = clr_ack_q;

endmodule

// File: tb/tb_axis_block_detector.sv
// Randomized + directed bench for axis_block_detector against a run-length reference model.
// Latency: outputs checked 1 time unit after every rising clock edge.
// Backpressure: n/a; the bench drives channel handshakes directly.
module tb_axis_block_detector;

  localparam int NUM_CH = 2;
  localparam int THRESH = 4;
  localparam int CNT_W  = 8;
  localparam int TS_W   = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NUM_CH-1:0] ch_tvalid = '0;
  logic [NUM_CH-1:0] ch_tready = '0;
  logic [NUM_CH-1:0] ch_dir = '0;
  logic [NUM_CH-1:0] ch_en = '0;
  logic              inst_idle = 1'b0;
  logic              clr_req = 1'b0;
  logic [NUM_CH-1:0] axis_block_sigs;
  logic              any_block;
  logic              first_valid;
  logic [0:0]        first_ch;
  logic [TS_W-1:0]   first_ts;
  logic              clr_ack;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: length of the current uninterrupted stall run per channel,
  // cycles elapsed since reset, and the record/handshake as described behaviourally.
  int              run_m [NUM_CH];
  logic [NUM_CH-1:0] blk_m;
  int              cyc_m;
  bit              fv_m;
  int              fch_m;
  int              fts_m;
  bit              ack_m;

  axis_block_detector #(
    .NUM_CH (NUM_CH),
    .THRESH (THRESH),
    .CNT_W  (CNT_W),
    .TS_W   (TS_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .ch_tvalid       (ch_tvalid),
    .ch_tready       (ch_tready),
    .ch_dir          (ch_dir),
    .ch_en           (ch_en),
    .inst_idle       (inst_idle),
    .axis_block_sigs (axis_block_sigs),
    .any_block       (any_block),
    .first_valid     (first_valid),
    .first_ch        (first_ch),
    .first_ts        (first_ts),
    .clr_req         (clr_req),
    .clr_ack         (clr_ack)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) run_m[i] = 0;
    blk_m = '0;
    cyc_m = 0;
    fv_m  = 0;
    fch_m = 0;
    fts_m = 0;
    ack_m = 0;
  endtask

  // Advance the model by one clock using the inputs that were stable before the edge.
  task automatic model_step();
    logic [NUM_CH-1:0] prev;
    logic [NUM_CH-1:0] rose;
    bit stalled;
    bit clear;
    prev = blk_m;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_dir[i]) stalled = ch_tvalid[i] && !ch_tready[i];
      else           stalled = ch_tready[i] && !ch_tvalid[i];
      stalled = stalled && ch_en[i] && !inst_idle;
      run_m[i] = stalled ? run_m[i] + 1 : 0;
      blk_m[i] = (run_m[i] >= THRESH);
    end
    rose  = blk_m & ~prev;
    clear = clr_req && !ack_m;
    if (clear) begin
      fv_m = 0; fch_m = 0; fts_m = 0;
    end else if (!fv_m && rose != 0) begin
      fv_m  = 1;
      fts_m = cyc_m % (1 << TS_W);
      fch_m = rose[0] ? 0 : 1;
    end
    ack_m = clear;
    cyc_m++;
  endtask

  task automatic check_all();
    check_eq("blk_sigs",    32'(axis_block_sigs), 32'(blk_m));
    check_eq("any_block",   32'(any_block),       32'(|blk_m));
    check_eq("first_valid", 32'(first_valid),     32'(fv_m));
    check_eq("first_ch",    32'(first_ch),        32'(fch_m));
    check_eq("first_ts",    32'(first_ts),        32'(fts_m));
    check_eq("clr_ack",     32'(clr_ack),         32'(ack_m));
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      model_step();
      check_all();
    end
  endtask

  // Asynchronous reset between edges: outputs must clear without a clock.
  task automatic async_reset();
    #3;
    reset = 1'b0;
    #1;
    check_eq("arst_blk",  32'(axis_block_sigs), 32'd0);
    check_eq("arst_any",  32'(any_block),       32'd0);
    check_eq("arst_fv",   32'(first_valid),     32'd0);
    check_eq("arst_fts",  32'(first_ts),        32'd0);
    check_eq("arst_ack",  32'(clr_ack),         32'd0);
    model_reset();
    #2;
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #23;
    check_eq("rst_blk",  32'(axis_block_sigs), 32'd0);
    check_eq("rst_any",  32'(any_block),       32'd0);
    check_eq("rst_fv",   32'(first_valid),     32'd0);
    check_eq("rst_fch",  32'(first_ch),        32'd0);
    check_eq("rst_fts",  32'(first_ts),        32'd0);
    check_eq("rst_ack",  32'(clr_ack),         32'd0);
    #4;
    reset = 1'b1;

    // Read stall on ch0 from cycle 0: block visible from cycle 4, stamped 3.
    ch_en = 2'b11; ch_dir = 2'b10; ch_tvalid = 2'b00; ch_tready = 2'b01;
    step(3);
    check_eq("tp1_pre", 32'(axis_block_sigs), 32'd0);
    step(1);
    check_eq("tp1_blk", 32'(axis_block_sigs), 32'd1);
    check_eq("tp1_fv",  32'(first_valid),     32'd1);
    check_eq("tp1_fch", 32'(first_ch),        32'd0);
    check_eq("tp1_fts", 32'(first_ts),        32'd3);

    // Clear while ch0 stays blocked: no recapture.
    clr_req = 1'b1; step(1);
    check_eq("clr_ack1", 32'(clr_ack),     32'd1);
    check_eq("clr_fv",   32'(first_valid), 32'd0);
    clr_req = 1'b0; step(2);
    check_eq("clr_ack0", 32'(clr_ack),     32'd0);
    check_eq("no_recap", 32'(first_valid), 32'd0);

    // Write stall on ch1 interrupted by one transfer: counter restarts.
    ch_tready = 2'b00; ch_tvalid = 2'b10;
    step(3);
    ch_tready = 2'b10; step(1);
    ch_tready = 2'b00; step(3);
    check_eq("wr_pre", 32'(axis_block_sigs[1]), 32'd0);
    step(1);
    check_eq("wr_blk", 32'(axis_block_sigs[1]), 32'd1);
    check_eq("wr_fch", 32'(first_ch),           32'd1);

    // Simultaneous rise on both channels: lowest index wins.
    clr_req = 1'b1; ch_tvalid = 2'b00; step(1);
    clr_req = 1'b0; step(1);
    ch_tvalid = 2'b10; ch_tready = 2'b01; step(4);
    check_eq("sim_blk", 32'(axis_block_sigs), 32'd3);
    check_eq("sim_fch", 32'(first_ch),        32'd0);

    // Idle interrupts a stall run; then drop ch_en[0] while blocked.
    inst_idle = 1'b1; step(1);
    check_eq("idle_clr", 32'(axis_block_sigs), 32'd0);
    inst_idle = 1'b0; step(2);
    inst_idle = 1'b1; step(1);
    inst_idle = 1'b0; step(2);
    check_eq("idle_noblk", 32'(axis_block_sigs), 32'd0);
    step(2);
    ch_en = 2'b10; ch_tvalid = 2'b00; step(1);
    check_eq("en_drop", 32'(axis_block_sigs[0]), 32'd0);
    check_eq("en_any",  32'(any_block),          32'(axis_block_sigs[1]));

    // Held clear request: acks every second cycle.
    ch_en = 2'b11;
    clr_req = 1'b1;
    step(1); check_eq("hold_ack1", 32'(clr_ack), 32'd1);
    step(1); check_eq("hold_ack2", 32'(clr_ack), 32'd0);
    step(1); check_eq("hold_ack3", 32'(clr_ack), 32'd1);
    step(1); check_eq("hold_ack4", 32'(clr_ack), 32'd0);
    clr_req = 1'b0;

    // Async reset while blocked.
    ch_tvalid = 2'b00; ch_tready = 2'b01; ch_dir = 2'b10;
    step(5);
    async_reset();
    step(1);

    // Random phase: sticky inputs so stall runs reach the threshold.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) ch_tvalid = NUM_CH'($urandom);
      if ($urandom_range(0, 5) == 0) ch_tready = NUM_CH'($urandom);
      if ($urandom_range(0, 40) == 0) ch_dir = NUM_CH'($urandom);
      ch_en     = ($urandom_range(0, 30) == 0) ? NUM_CH'($urandom) : (ch_en | NUM_CH'($urandom_range(0, 3) == 0 ? 3 : 0));
      inst_idle = ($urandom_range(0, 24) == 0);
      clr_req   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) async_reset();
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
